id_ex_stage_reg: RTL and testbench

- ID/EX pipeline register on the producer side of the execute-stage input interface.
- Captures the decode bundle: control signals, PC+4, two register-file reads, sign-extended immediate, rs/rt/rd fields.
- Presents the bundle to the execute stage with valid/ready flow control, a 2-entry skid buffer, flush support and bubble insertion.
- Decouples decode from downstream stalls without a combinational ready path.

---
 rtl/id_ex_stage_reg.sv | 207 ++++++++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//   ID/EX pipeline register feeding the execute stage. Holds the decode
//   bundle (controls, PC+4, two register reads, immediate, rs/rt/rd) in a
//   main entry that drives the outputs, backed by a skid entry so that
//   oready is a registered term (no combinational path from iready).
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   iflush                   synchronous squash of main and skid entries
//   ivalid / oready          decode-side handshake
//   ipc4, iread_1, iread_2,
//   iimm, irs, irt, ird,
//   iSig_*                   decode bundle
//   ovalid / iready          execute-side handshake
//   opc4 ... oSig_*          registered bundle; Branch/MemRead/MemWrite/
//                            RegWrite read 0 whenever ovalid is 0
//
// Configuration
//   ID_EX_LOAD_USE_EN        when defined, adds load-use hazard detection
//                            that withholds oready while a dependent
//                            instruction follows a load.
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iflush,
  input  logic              ivalid,
  output logic              oready,
  input  logic [DATA_W-1:0] ipc4,
  input  logic [DATA_W-1:0] iread_1,
  input  logic [DATA_W-1:0] iread_2,
  input  logic [DATA_W-1:0] iimm,
  input  logic [REG_AW-1:0] irs,
  input  logic [REG_AW-1:0] irt,
  input  logic [REG_AW-1:0] ird,
  input  logic              iSig_RegDst,
  input  logic [1:0]        iSig_ALUOp,
  input  logic              iSig_ALUSrc,
  input  logic              iSig_Branch,
  input  logic              iSig_MemRead,
  input  logic              iSig_MemWrite,
  input  logic              iSig_RegWrite,
  input  logic              iSig_MemtoReg,
  output logic              ovalid,
  input  logic              iready,
  output logic [DATA_W-1:0] opc4,
  output logic [DATA_W-1:0] oread_1,
  output logic [DATA_W-1:0] oread_2,
  output logic [DATA_W-1:0] oimm,
  output logic [REG_AW-1:0] ors,
  output logic [REG_AW-1:0] ort,
  output logic [REG_AW-1:0] ord,
  output logic              oSig_RegDst,
  output logic [1:0]        oSig_ALUOp,
  output logic              oSig_ALUSrc,
  output logic              oSig_Branch,
  output logic              oSig_MemRead,
  output logic              oSig_MemWrite,
  output logic              oSig_RegWrite,
  output logic              oSig_MemtoReg
);

  typedef struct packed {
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] read_1;
    logic [DATA_W-1:0] read_2;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              regdst;
    logic [1:0]        aluop;
    logic              alusrc;
    logic              branch;
    logic              memread;
    logic              memwrite;
    logic              regwrite;
    logic              memtoreg;
  } bundle_t;

  // Side-effecting controls are cleared in the stored main entry whenever it
  // goes empty, so the gated outputs stay purely registered.
  function automatic bundle_t gate_bubble(input bundle_t b);
    bundle_t g;
    g          = b;
    g.branch   = 1'b0;
    g.memread  = 1'b0;
    g.memwrite = 1'b0;
    g.regwrite = 1'b0;
    return g;
  endfunction

  bundle_t in_b;
  bundle_t main_q, main_n;
  bundle_t skid_q, skid_n;
  logic    main_valid, main_valid_n;
  logic    skid_valid, skid_valid_n;
  logic    in_hs;
  logic    out_hs;

  assign in_b = {ipc4, iread_1, iread_2, iimm, irs, irt, ird,
                 iSig_RegDst, iSig_ALUOp, iSig_ALUSrc, iSig_Branch,
                 iSig_MemRead, iSig_MemWrite, iSig_RegWrite, iSig_MemtoReg};

  assign in_hs  = ivalid & oready;
  assign out_hs = main_valid & iready;

`ifdef ID_EX_LOAD_USE_EN
  logic              lu_valid;
  logic [REG_AW-1:0] lu_rt;
  logic              hazard;
  logic              main_dep;
  logic              lu_dep;

  // A load sitting in EX (main) or in MEM (lu_*) blocks a consumer of its rt;
  // register 0 is never a real dependency.
  assign main_dep = main_valid & main_q.memread & (main_q.rt != {REG_AW{1'b0}})
                    & ((main_q.rt == irs) | (main_q.rt == irt));
  assign lu_dep   = lu_valid & (lu_rt != {REG_AW{1'b0}})
                    & ((lu_rt == irs) | (lu_rt == irt));
  assign hazard   = ivalid & (main_dep | lu_dep);
  assign oready   = ~skid_valid & ~hazard;

  // Track the load that has just left for MEM until the next advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_valid <= 1'b0;
      lu_rt    <= {REG_AW{1'b0}};
    end else if (iflush) begin
      lu_valid <= 1'b0;
    end else if (out_hs & main_q.memread) begin
      lu_valid <= 1'b1;
      lu_rt    <= main_q.rt;
    end else if (iready) begin
      lu_valid <= 1'b0;
    end
  end
`else
  assign oready = ~skid_valid;
`endif

  // Next-state for main/skid entries; skid only fills while main is stalled.
  always_comb begin
    main_n       = main_q;
    skid_n       = skid_q;
    main_valid_n = main_valid;
    skid_valid_n = skid_valid;
    if (iflush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
      main_n       = gate_bubble(main_q);
    end else if (out_hs & skid_valid) begin
      // oready is low while skid is full, so no input can arrive here.
      main_n       = skid_q;
      main_valid_n = 1'b1;
      skid_valid_n = 1'b0;
    end else if (in_hs & (~main_valid | out_hs)) begin
      main_n       = in_b;
      main_valid_n = 1'b1;
    end else if (in_hs) begin
      skid_n       = in_b;
      skid_valid_n = 1'b1;
    end else if (out_hs) begin
      main_valid_n = 1'b0;
      main_n       = gate_bubble(main_q);
    end else begin
      main_n       = main_q;
    end
  end

  // Entry state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      main_q     <= main_n;
      skid_q     <= skid_n;
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
    end
  end

  assign ovalid        = main_valid;
  assign opc4          = main_q.pc4;
  assign oread_1       = main_q.read_1;
  assign oread_2       = main_q.read_2;
  assign oimm          = main_q.imm;
  assign ors           = main_q.rs;
  assign ort           = main_q.rt;
  assign ord           = main_q.rd;
  assign oSig_RegDst   = main_q.regdst;
  assign oSig_ALUOp    = main_q.aluop;
  assign oSig_ALUSrc   = main_q.alusrc;
  assign oSig_Branch   = main_q.branch;
  assign oSig_MemRead  = main_q.memread;
  assign oSig_MemWrite = main_q.memwrite;
  assign oSig_RegWrite = main_q.regwrite;
  assign oSig_MemtoReg = main_q.memtoreg;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
//   Directed self-checking bench for id_ex_stage_reg. Inputs change 1 time
//   unit after the rising edge; outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  logic        clk;
  logic        rst;
  logic        iflush;
  logic        ivalid;
  logic        oready;
  logic [31:0] ipc4, iread_1, iread_2, iimm;
  logic [4:0]  irs, irt, ird;
  logic        iSig_RegDst;
  logic [1:0]  iSig_ALUOp;
  logic        iSig_ALUSrc, iSig_Branch, iSig_MemRead, iSig_MemWrite;
  logic        iSig_RegWrite, iSig_MemtoReg;
  logic        ovalid;
  logic        iready;
  logic [31:0] opc4, oread_1, oread_2, oimm;
  logic [4:0]  ors, ort, ord;
  logic        oSig_RegDst;
  logic [1:0]  oSig_ALUOp;
  logic        oSig_ALUSrc, oSig_Branch, oSig_MemRead, oSig_MemWrite;
  logic        oSig_RegWrite, oSig_MemtoReg;

  int checks;
  int failures;

  id_ex_stage_reg #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .iflush(iflush), .ivalid(ivalid), .oready(oready),
    .ipc4(ipc4), .iread_1(iread_1), .iread_2(iread_2), .iimm(iimm),
    .irs(irs), .irt(irt), .ird(ird),
    .iSig_RegDst(iSig_RegDst), .iSig_ALUOp(iSig_ALUOp), .iSig_ALUSrc(iSig_ALUSrc),
    .iSig_Branch(iSig_Branch), .iSig_MemRead(iSig_MemRead),
    .iSig_MemWrite(iSig_MemWrite), .iSig_RegWrite(iSig_RegWrite),
    .iSig_MemtoReg(iSig_MemtoReg),
    .ovalid(ovalid), .iready(iready),
    .opc4(opc4), .oread_1(oread_1), .oread_2(oread_2), .oimm(oimm),
    .ors(ors), .ort(ort), .ord(ord),
    .oSig_RegDst(oSig_RegDst), .oSig_ALUOp(oSig_ALUOp), .oSig_ALUSrc(oSig_ALUSrc),
    .oSig_Branch(oSig_Branch), .oSig_MemRead(oSig_MemRead),
    .oSig_MemWrite(oSig_MemWrite), .oSig_RegWrite(oSig_RegWrite),
    .oSig_MemtoReg(oSig_MemtoReg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ctl = {RegDst, ALUOp[1:0], ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg}
  task automatic set_in(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [8:0] ctl);
    ivalid        = v;
    ipc4          = pc;
    iread_1       = 32'h1000_0000 | pc;
    iread_2       = 32'h2000_0000 | pc;
    iimm          = 32'h3000_0000 | pc;
    irs           = rs;
    irt           = rt;
    ird           = 5'd0;
    iSig_RegDst   = ctl[8];
    iSig_ALUOp    = ctl[7:6];
    iSig_ALUSrc   = ctl[5];
    iSig_Branch   = ctl[4];
    iSig_MemRead  = ctl[3];
    iSig_MemWrite = ctl[2];
    iSig_RegWrite = ctl[1];
    iSig_MemtoReg = ctl[0];
  endtask

  task automatic test_reset();
    #3;
    checks += 3;
    if (ovalid !== 1'b0) begin failures++; $display("FAIL reset_ovalid got=%b exp=0", ovalid); end
    if (oready !== 1'b1) begin failures++; $display("FAIL reset_oready got=%b exp=1", oready); end
    if (opc4 !== 32'h0) begin failures++; $display("FAIL reset_opc4 got=%h exp=0", opc4); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fields();
    iready = 1'b1;
    ivalid        = 1'b1;
    ipc4          = 32'h0000_0104;
    iread_1       = 32'hDEAD_BEEF;
    iread_2       = 32'h0123_4567;
    iimm          = 32'hFFFF_FFF0;
    irs           = 5'd3;
    irt           = 5'd17;
    ird           = 5'd30;
    iSig_RegDst   = 1'b1;
    iSig_ALUOp    = 2'b10;
    iSig_ALUSrc   = 1'b0;
    iSig_Branch   = 1'b0;
    iSig_MemRead  = 1'b0;
    iSig_MemWrite = 1'b0;
    iSig_RegWrite = 1'b1;
    iSig_MemtoReg = 1'b0;
    tick();
    checks += 3;
    if ({ovalid, opc4, oread_1, oread_2, oimm} !==
        {1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0123_4567, 32'hFFFF_FFF0}) begin
      failures++;
      $display("FAIL fields_data got=%b %h %h %h %h exp=1 00000104 deadbeef 01234567 fffffff0",
               ovalid, opc4, oread_1, oread_2, oimm);
    end
    if ({ors, ort, ord} !== {5'd3, 5'd17, 5'd30}) begin
      failures++; $display("FAIL fields_regs got=%0d %0d %0d exp=3 17 30", ors, ort, ord);
    end
    if ({oSig_RegDst, oSig_ALUOp, oSig_ALUSrc, oSig_Branch, oSig_MemRead, oSig_MemWrite,
         oSig_RegWrite, oSig_MemtoReg} !== 9'b1_10_0_0_0_0_1_0) begin
      failures++;
      $display("FAIL fields_ctl got=%b%b%b%b%b%b%b%b exp=110000010", oSig_RegDst, oSig_ALUOp,
               oSig_ALUSrc, oSig_Branch, oSig_MemRead, oSig_MemWrite, oSig_RegWrite, oSig_MemtoReg);
    end
    set_in(1'b0, 32'h0, 5'd0, 5'd0, 9'h000);
    tick();
    checks++;
    if (ovalid !== 1'b0) begin failures++; $display("FAIL fields_drain got=%b exp=0", ovalid); end
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [4];
    pcs[0] = 32'h4; pcs[1] = 32'h8; pcs[2] = 32'hC; pcs[3] = 32'h10;
    iready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, pcs[i], 5'd1, 5'd2, 9'h002);
      tick();
      checks += 2;
      if (ovalid !== 1'b1 || opc4 !== pcs[i]) begin
        failures++; $display("FAIL stream_%0d got=%b/%h exp=1/%h", i, ovalid, opc4, pcs[i]);
      end
      if (oready !== 1'b1) begin failures++; $display("FAIL stream_ready_%0d got=%b exp=1", i, oready); end
    end
    set_in(1'b0, 32'h0, 5'd0, 5'd0, 9'h000);
    tick();
    checks++;
    if (ovalid !== 1'b0) begin failures++; $display("FAIL stream_end got=%b exp=0", ovalid); end
  endtask

  task automatic test_backpressure();
    iready = 1'b0;
    set_in(1'b1, 32'h20, 5'd1, 5'd2, 9'h002);
    tick();
    checks++;
    if (ovalid !== 1'b1 || opc4 !== 32'h20 || oready !== 1'b1) begin
      failures++; $display("FAIL bp_first got=%b/%h/%b exp=1/20/1", ovalid, opc4, oready);
    end
    set_in(1'b1, 32'h24, 5'd1, 5'd2, 9'h002);
    tick();
    checks++;
    if (opc4 !== 32'h20 || oready !== 1'b0) begin
      failures++; $display("FAIL bp_skid got=%h/%b exp=20/0", opc4, oready);
    end
    set_in(1'b1, 32'h28, 5'd1, 5'd2, 9'h002);
    tick();
    checks++;
    if (ovalid !== 1'b1 || opc4 !== 32'h20 || oready !== 1'b0) begin
      failures++; $display("FAIL bp_hold got=%b/%h/%b exp=1/20/0", ovalid, opc4, oready);
    end
    iready = 1'b1;
    tick();
    checks++;
    if (ovalid !== 1'b1 || opc4 !== 32'h24 || oready !== 1'b1) begin
      failures++; $display("FAIL bp_rel1 got=%b/%h/%b exp=1/24/1", ovalid, opc4, oready);
    end
    tick();
    checks++;
    if (ovalid !== 1'b1 || opc4 !== 32'h28) begin
      failures++; $display("FAIL bp_rel2 got=%b/%h exp=1/28", ovalid, opc4);
    end
    set_in(1'b0, 32'h0, 5'd0, 5'd0, 9'h000);
    tick();
    checks++;
    if (ovalid !== 1'b0) begin failures++; $display("FAIL bp_end got=%b exp=0", ovalid); end
  endtask

  task automatic test_flush();
    iready = 1'b0;
    set_in(1'b1, 32'h30, 5'd1, 5'd2, 9'h1FF);
    tick();
    checks++;
    if ({oSig_Branch, oSig_MemRead, oSig_MemWrite, oSig_RegWrite} !== 4'hF) begin
      failures++; $display("FAIL flush_pre_ctl got=%b%b%b%b exp=1111",
                           oSig_Branch, oSig_MemRead, oSig_MemWrite, oSig_RegWrite);
    end
    set_in(1'b1, 32'h34, 5'd1, 5'd2, 9'h1FF);
    tick();
    set_in(1'b1, 32'h38, 5'd1, 5'd2, 9'h1FF);
    iflush = 1'b1;
    tick();
    iflush = 1'b0;
    checks += 3;
    if (ovalid !== 1'b0) begin failures++; $display("FAIL flush_ovalid got=%b exp=0", ovalid); end
    if (oready !== 1'b1) begin failures++; $display("FAIL flush_oready got=%b exp=1", oready); end
    if ({oSig_Branch, oSig_MemRead, oSig_MemWrite, oSig_RegWrite} !== 4'h0) begin
      failures++; $display("FAIL flush_ctl got=%b%b%b%b exp=0000",
                           oSig_Branch, oSig_MemRead, oSig_MemWrite, oSig_RegWrite);
    end
    set_in(1'b0, 32'h0, 5'd0, 5'd0, 9'h000);
    iready = 1'b1;
    tick();
    checks++;
    if (ovalid !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%b exp=0", ovalid); end
  endtask

  task automatic test_bubble();
    iready = 1'b0;
    set_in(1'b1, 32'h40, 5'd1, 5'd2, 9'h003);
    tick();
    checks++;
    if (oSig_RegWrite !== 1'b1) begin failures++; $display("FAIL bubble_pre got=%b exp=1", oSig_RegWrite); end
    set_in(1'b0, 32'h0, 5'd0, 5'd0, 9'h000);
    iready = 1'b1;
    tick();
    checks += 3;
    if (ovalid !== 1'b0) begin failures++; $display("FAIL bubble_ovalid got=%b exp=0", ovalid); end
    if (oSig_RegWrite !== 1'b0) begin failures++; $display("FAIL bubble_regwrite got=%b exp=0", oSig_RegWrite); end
    if (opc4 !== 32'h40 || oSig_MemtoReg !== 1'b1) begin
      failures++; $display("FAIL bubble_hold got=%h/%b exp=40/1", opc4, oSig_MemtoReg);
    end
  endtask

  task automatic test_reset_midstream();
    iready = 1'b0;
    set_in(1'b1, 32'h50, 5'd4, 5'd5, 9'h1FF);
    tick();
    set_in(1'b1, 32'h54, 5'd6, 5'd7, 9'h1FF);
    tick();
    checks++;
    if (oready !== 1'b0) begin failures++; $display("FAIL rstmid_full got=%b exp=0", oready); end
    #2;
    rst = 1'b1;
    #1;
    checks += 3;
    if (ovalid !== 1'b0 || oready !== 1'b1) begin
      failures++; $display("FAIL rstmid_hs got=%b/%b exp=0/1", ovalid, oready);
    end
    if ({opc4, oread_1, oread_2, oimm} !== 128'h0) begin
      failures++; $display("FAIL rstmid_data got=%h %h %h %h exp=0", opc4, oread_1, oread_2, oimm);
    end
    if ({ors, ort, ord, oSig_RegDst, oSig_ALUOp, oSig_ALUSrc, oSig_Branch, oSig_MemRead,
         oSig_MemWrite, oSig_RegWrite, oSig_MemtoReg} !== 24'h0) begin
      failures++; $display("FAIL rstmid_ctl got=%0d %0d %0d ctl nonzero exp=0", ors, ort, ord);
    end
    set_in(1'b0, 32'h0, 5'd0, 5'd0, 9'h000);
    #2;
    rst = 1'b0;
    tick();
    checks++;
    if (ovalid !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%b exp=0", ovalid); end
  endtask

`ifdef ID_EX_LOAD_USE_EN
  task automatic test_load_use();
    iready = 1'b0;
    set_in(1'b1, 32'h60, 5'd9, 5'd8, 9'h02B);
    tick();
    set_in(1'b1, 32'h64, 5'd8, 5'd3, 9'h002);
    #1;
    checks++;
    if (oready !== 1'b0) begin failures++; $display("FAIL lu_main got=%b exp=0", oready); end
    iready = 1'b1;
    tick();
    checks++;
    if (ovalid !== 1'b0 || oready !== 1'b0) begin
      failures++; $display("FAIL lu_mem got=%b/%b exp=0/0", ovalid, oready);
    end
    tick();
    checks++;
    if (oready !== 1'b1) begin failures++; $display("FAIL lu_clear got=%b exp=1", oready); end
    tick();
    checks++;
    if (ovalid !== 1'b1 || opc4 !== 32'h64) begin
      failures++; $display("FAIL lu_accept got=%b/%h exp=1/64", ovalid, opc4);
    end
    set_in(1'b1, 32'h68, 5'd0, 5'd0, 9'h02B);
    tick();
    set_in(1'b1, 32'h6C, 5'd0, 5'd0, 9'h002);
    #1;
    checks++;
    if (oready !== 1'b1) begin failures++; $display("FAIL lu_r0 got=%b exp=1", oready); end
    tick();
    set_in(1'b0, 32'h0, 5'd0, 5'd0, 9'h000);
    tick();
    tick();
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    iflush   = 1'b0;
    iready   = 1'b0;
    set_in(1'b0, 32'h0, 5'd0, 5'd0, 9'h000);
    test_reset();
    test_fields();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble();
    test_reset_midstream();
`ifdef ID_EX_LOAD_USE_EN
    test_load_use();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
